// File: rtl/data_memory_ws.sv
// Byte/half/word data memory with a Req/Ready handshake and LATENCY wait states.
// Define DMEM_BIG_ENDIAN_EN for big-endian lane mapping (little-endian otherwise).
module data_memory_ws #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       Write_data,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    output logic              Ready,
    output logic              Err,
    output logic              Busy,
    output logic [31:0]       Read_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               we_q;
    logic               re_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               ready_q;
    logic               err_q;
    logic               busy_q;
    logic [31:0]        rdata_q;
    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]   idx;
    logic               oor;
    logic               err_c;
    logic [4:0]         sh;
    logic [31:0]        mask;
    logic [31:0]        word_rd;
    logic [31:0]        shifted;
    logic [31:0]        rdata_d;
    logic [31:0]        mem_wr_d;

    // Decode the captured request: legality, lane shift, load extract and store merge
    always_comb begin
        idx      = addr_q[IDX_W+1:2];
        oor      = (64'(addr_q) >= 64'(4 * DEPTH_WORDS));
        err_c    = (we_q == re_q) || (size_q == 2'b11) ||
                   ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)) || oor;
        sh       = 5'd0;
`ifdef DMEM_BIG_ENDIAN_EN
        if (size_q == 2'b00)      sh = {~addr_q[1:0], 3'b000};
        else if (size_q == 2'b01) sh = {~addr_q[1], 4'b0000};
`else
        if (size_q == 2'b00)      sh = {addr_q[1:0], 3'b000};
        else if (size_q == 2'b01) sh = {addr_q[1], 4'b0000};
`endif
        case (size_q)
            2'b00:   mask = 32'h0000_00FF << sh;
            2'b01:   mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        word_rd  = mem_q[idx];
        shifted  = word_rd >> sh;
        case (size_q)
            2'b00:   rdata_d = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
            2'b01:   rdata_d = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_d = shifted;
        endcase
        mem_wr_d = (word_rd & ~mask) | ((wdata_q << sh) & mask);
    end

    // Handshake FSM, request capture, array update and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[IDX_W'(i)] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Req) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_W'(LATENCY);
                        addr_q  <= Address;
                        wdata_q <= Write_data;
                        we_q    <= MemWrite;
                        re_q    <= MemRead;
                        size_q  <= Size;
                        uns_q   <= Unsigned;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        err_q   <= err_c;
                        if (!err_c && we_q) mem_q[idx] <= mem_wr_d;
                        if (!err_c && re_q) rdata_q    <= rdata_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Ready     = ready_q;
    assign Err       = err_q;
    assign Busy      = busy_q;
    assign Read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Randomised bench for data_memory_ws against a byte-array memory model.
module tb_data_memory_ws;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned NBYTE = DEPTH * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          Req;
    logic [AW-1:0] Address;
    logic [31:0]   Write_data;
    logic          MemWrite;
    logic          MemRead;
    logic [1:0]    Size;
    logic          Unsigned;
    logic          Ready;
    logic          Err;
    logic          Busy;
    logic [31:0]   Read_data;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    mb [NBYTE];
    logic [31:0]   m_rd;

    data_memory_ws #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .Req(Req), .Address(Address), .Write_data(Write_data),
        .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
        .Ready(Ready), .Err(Err), .Busy(Busy), .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NBYTE); i++) mb[i] = 8'h00;
        m_rd = 32'h0;
    endtask

    // Memory as a flat byte array; lane order only decides which byte holds which bits
    task automatic model_access(input logic we, input logic re, input logic [1:0] sz,
                                input logic u, input logic [31:0] a, input logic [31:0] wd,
                                output logic err);
        int unsigned n;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (we == re) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
              (sz == 2'd2 && a[1:0] != 2'd0) || (a >= NBYTE);
        if (err) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++) begin
`ifdef DMEM_BIG_ENDIAN_EN
                mb[a + i] = 8'(wd >> (8 * (int'(n) - 1 - i)));
`else
                mb[a + i] = 8'(wd >> (8 * i));
`endif
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(n); i++) begin
`ifdef DMEM_BIG_ENDIAN_EN
                v = (v << 8) | 32'(mb[a + i]);
`else
                v = v | (32'(mb[a + i]) << (8 * i));
`endif
            end
            if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            m_rd = v;
        end
    endtask

    // Issue one request from a negedge, return at the negedge of the Ready cycle
    task automatic do_req(input string tag, input logic we, input logic re, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          output logic err_o, output logic [31:0] rd_o);
        logic exp_err;
        int   n;
        int   nbusy;
        logic got;
        Address = a; Write_data = wd; MemWrite = we; MemRead = re; Size = sz; Unsigned = u;
        Req = 1'b1;
        model_access(we, re, sz, u, a, wd, exp_err);
        @(negedge clk);
        Req = 1'b0;
        Address = $urandom; Write_data = $urandom; MemWrite = 1'($urandom);
        MemRead = 1'($urandom); Size = 2'($urandom); Unsigned = 1'($urandom);
        n = 1; nbusy = 0; got = 1'b0;
        while (n <= 20) begin
            if (Ready) begin
                got = 1'b1;
                break;
            end
            if (Busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(LAT + 2));
        chk({tag, "_busy"}, 32'(nbusy), 32'(LAT + 1));
        chk({tag, "_err"}, 32'(Err), 32'(exp_err));
        chk({tag, "_rdata"}, Read_data, m_rd);
        err_o = Err;
        rd_o  = Read_data;
    endtask

    logic        e;
    logic [31:0] r;
    logic [31:0] exp_q [3];
    logic [31:0] b2b_a [3];
    logic        d_err;

    initial begin
        rst = 1'b0; Req = 1'b1; Address = 32'h10; Write_data = 32'hFFFF_FFFF;
        MemWrite = 1'b1; MemRead = 1'b0; Size = 2'd2; Unsigned = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_rdata", Read_data, 32'd0);
        Req = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        do_req("lw10", 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, e, r);
        chk("lw10_val", r, 32'h0);
        do_req("sw20", 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h8899AABB, e, r);
        do_req("lb21s", 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0, e, r);
`ifdef DMEM_BIG_ENDIAN_EN
        chk("lb21s_val", r, 32'hFFFF_FF99);
`else
        chk("lb21s_val", r, 32'hFFFF_FFAA);
`endif
        do_req("lb21u", 1'b0, 1'b1, 2'd0, 1'b1, 32'h21, 32'h0, e, r);
`ifdef DMEM_BIG_ENDIAN_EN
        chk("lb21u_val", r, 32'h0000_0099);
`else
        chk("lb21u_val", r, 32'h0000_00AA);
`endif
        do_req("lh22s", 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0, e, r);
`ifdef DMEM_BIG_ENDIAN_EN
        chk("lh22s_val", r, 32'hFFFF_AABB);
`else
        chk("lh22s_val", r, 32'hFFFF_8899);
`endif
        do_req("lb20s", 1'b0, 1'b1, 2'd0, 1'b0, 32'h20, 32'h0, e, r);
`ifdef DMEM_BIG_ENDIAN_EN
        chk("lb20s_val", r, 32'hFFFF_FF88);
`else
        chk("lb20s_val", r, 32'hFFFF_FFBB);
`endif
        do_req("sb23", 1'b1, 1'b0, 2'd0, 1'b0, 32'h23, 32'hFFFF_FF5A, e, r);
        do_req("lw20", 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, e, r);
`ifdef DMEM_BIG_ENDIAN_EN
        chk("merge_val", r, 32'h8899_AA5A);
`else
        chk("merge_val", r, 32'h5A99_AABB);
`endif

        do_req("e_mis", 1'b0, 1'b1, 2'd2, 1'b0, 32'h22, 32'h0, e, r);
        chk("e_mis_flag", 32'(e), 32'd1);
        do_req("e_sz3", 1'b0, 1'b1, 2'd3, 1'b0, 32'h20, 32'h0, e, r);
        chk("e_sz3_flag", 32'(e), 32'd1);
        do_req("e_both", 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, e, r);
        chk("e_both_flag", 32'(e), 32'd1);
        do_req("e_oor", 1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, e, r);
        chk("e_oor_flag", 32'(e), 32'd1);
        do_req("lw0", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, e, r);
        chk("lw0_val", r, 32'h0);
        chk("lw0_flag", 32'(e), 32'd0);

        // Three loads with Req held: one Ready per LAT+2 cycles, Busy low only in DONE
        b2b_a[0] = 32'h20; b2b_a[1] = 32'h10; b2b_a[2] = 32'h24;
        Address = b2b_a[0]; MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Unsigned = 1'b0;
        Req = 1'b1;
        model_access(1'b0, 1'b1, 2'd2, 1'b0, b2b_a[0], 32'h0, d_err);
        exp_q[0] = m_rd;
        for (int n = 1; n <= 3 * int'(LAT + 2); n++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(Ready), 32'((n % int'(LAT + 2)) == 0));
            chk("b2b_busy", 32'(Busy), 32'((n % int'(LAT + 2)) != 0));
            if ((n % int'(LAT + 2)) == 0) begin
                int k;
                k = n / int'(LAT + 2) - 1;
                chk("b2b_rdata", Read_data, exp_q[k]);
                chk("b2b_err", 32'(Err), 32'd0);
                if (k < 2) begin
                    Address = b2b_a[k + 1];
                    model_access(1'b0, 1'b1, 2'd2, 1'b0, b2b_a[k + 1], 32'h0, d_err);
                    exp_q[k + 1] = m_rd;
                end else begin
                    Req = 1'b0;
                end
            end
        end

        for (int i = 0; i < 80; i++) begin
            int unsigned   kind;
            logic          we;
            logic          re;
            logic [1:0]    sz;
            logic [31:0]   a;
            kind = $urandom_range(0, 9);
            we = (kind == 1) || (kind >= 2 && kind <= 5);
            re = (kind == 1) || (kind >= 6);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(NBYTE - 8, NBYTE + 4))
                                             : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0]   = 1'b0;
            end
            do_req("rnd", we, re, sz, 1'($urandom), a, $urandom, e, r);
        end

        // Store aborted by reset during WAIT must leave no trace
        Address = 32'h30; Write_data = 32'h12345678; MemWrite = 1'b1; MemRead = 1'b0;
        Size = 2'd2; Unsigned = 1'b0; Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (4) begin
            @(negedge clk);
            chk("abort_ready", 32'(Ready), 32'd0);
            chk("abort_busy", 32'(Busy), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        do_req("lw30", 1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, e, r);
        chk("lw30_val", r, 32'h0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
- Parametrised successor to the single-cycle word data memory in the MIPS CPU.
- Adds a request/ready handshake with configurable wait states.
- Supports byte, half and word loads/stores, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal requests. Sits between the MEM pipeline stage and a stall controller.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of 2, 4..4096
LATENCY, 1, wait cycles before completion, 0..7
ADDR_W, 32, address width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
Req  input  1  request strobe
Address  input  ADDR_W  byte address
Write_data  input  32  store data; sub-word data taken from low bits
MemWrite  input  1  store request
MemRead  input  1  load request
Size  input  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
Ready  output  1  one-cycle completion pulse
Err  output  1  valid with Ready; 1 = request rejected
Busy  output  1  high while in WAIT
Read_data  output  32  load result

Behaviour:
- Reset (rst=0, asynchronous):
  - Ready=0, Err=0, Busy=0, Read_data=0, state=IDLE, counter=0.
  - Entire array cleared to 0.
- FSM states IDLE, WAIT, DONE.
- Acceptance:
  - A request is accepted on a rising edge in IDLE or DONE when Req=1.
  - Address, Write_data, MemWrite, MemRead, Size and Unsigned are captured at acceptance and ignored thereafter.
  - Accepted request moves the FSM to WAIT with counter=LATENCY.
- WAIT:
  - Busy=1.
  - Each edge with counter>0 decrements the counter.
  - The edge with counter=0 performs the access and moves to DONE.
- DONE:
  - Ready=1 for exactly one cycle.
  - The next edge goes to WAIT if a new Req is present, otherwise to IDLE.
- Timing:
  - Ready is high in the cycle after acceptance edge + LATENCY + 1 edges, i.e. LATENCY+2 cycles after the accepting edge.
  - Back-to-back throughput is one access per LATENCY+2 cycles.
- Req seen in WAIT is ignored; no queueing.
- Error conditions (Err=1 with Ready, no array change, Read_data unchanged):
  - MemWrite and MemRead both 1, or both 0.
  - Size=11.
  - Half with Address[0]=1.
  - Word with Address[1:0]!=0.
  - Address >= 4*DEPTH_WORDS. No wrap-around.
- Addressing:
  - Word index = Address[log2(DEPTH_WORDS)+1:2].
  - Lane = Address[1:0].
- Lane mapping (default, little-endian):
  - Byte lane k occupies bits [8k+7:8k].
  - Half at offset 0 occupies [15:0]; offset 2 occupies [31:16].
- Stores:
  - Read-modify-write of the addressed lanes only; other lanes preserved.
  - Committed on the completing edge.
- Loads:
  - Extracted lane is extended per Unsigned and registered into Read_data on the completing edge.
  - Read_data holds until the next successful load.
  - Stores never change Read_data.
- Reset asserted mid-operation:
  - Access aborted and store not committed.
  - No Ready pulse for the aborted request.

Optional Feature:
- Macro DMEM_BIG_ENDIAN_EN.
- Defined: big-endian lanes.
  - Byte offset 0 maps to [31:24], offset 3 to [7:0].
  - Half offset 0 maps to [31:16], offset 2 to [15:0].
- Undefined: little-endian mapping as above.
- Word access is identical in both modes.

Test Plan:
1. All cases use LATENCY=2, DEPTH_WORDS=256.
2. Reset: hold rst=0 for 3 cycles with Req=1 -> Ready=0, Busy=0, Read_data=0. After release, LW 0x10 -> Read_data=0x00000000, Err=0, Ready exactly 4 cycles after the accepting edge, Busy high 3 cycles.
3. Extension: SW 0x8899AABB @0x20, then:
   - LB @0x21 signed -> 0xFFFFFFAA.
   - LB @0x21 Unsigned=1 -> 0x000000AA.
   - LH @0x22 signed -> 0xFFFF8899.
   - With DMEM_BIG_ENDIAN_EN, LB @0x20 signed -> 0xFFFFFF88.
4. Sub-word merge: after case 3, SB 0x5A @0x23 then LW @0x20 -> 0x5A99AABB (little-endian) or 0x8899AA5A (big-endian).
5. Errors, each must give Ready=1 with Err=1:
   - LW @0x22.
   - Size=11.
   - MemRead=MemWrite=1.
   - SW 0xDEADBEEF @0x400 -> afterwards LW @0x000 returns 0, no wrap.
6. Abort and back-to-back:
   - SW 0x12345678 @0x30, drive rst=0 during WAIT -> no Ready; LW @0x30 -> 0.
   - Req held high with 3 queued LWs -> Ready pulses every 4 cycles, Busy=0 only in DONE cycles.
